// File: rtl/serdes_pkg.sv
// Shared definitions for the 12-bit serializer / deserializer pair.
// Both ends take their word size from WORD_W so they cannot drift apart.
//   WORD_W  : bits per serial word
//   CNT_W   : bit-counter width, wide enough to hold 0..WORD_W
//   state_t : receive FSM states
package serdes_pkg;

    localparam int unsigned WORD_W = 12;
    localparam int unsigned CNT_W  = $clog2(WORD_W + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/deser_bit_counter.sv
// Bit-position counter for the deserializer.
// Ports:
//   CLK, rst  : clock, asynchronous active-high reset
//   start     : load position of the bit after bit 0 (a framed first bit was taken)
//   advance   : a non-first bit was taken; step or wrap to 0 after the last bit
//   cnt       : index the next incoming bit will be written to
//   last_bit  : cnt addresses the final bit of the word
module deser_bit_counter #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned CNT_W = 4
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             start,
    input  logic             advance,
    output logic [CNT_W-1:0] cnt,
    output logic             last_bit
);

    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
    // A one-bit word completes on its framing bit, so the counter stays at 0.
    localparam logic [CNT_W-1:0] FIRST = (WIDTH == 1) ? '0 : CNT_W'(1);

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= FIRST;
        end else if (advance) begin
            cnt <= last_bit ? '0 : cnt + CNT_W'(1);
        end
    end

    assign last_bit = (cnt == LAST);

endmodule

// File: rtl/deserializer_rx.sv
// Receive side of the serial link: rebuilds LSB-first words from a strobed
// bit stream and presents them through a single-entry valid/ready register.
// Ports:
//   CLK, rst     : clock, asynchronous active-high reset
//   serial_in    : data bit, qualified by bit_valid
//   bit_valid    : serial_in carries a bit this cycle
//   frame_start  : with bit_valid, serial_in is bit 0 of a new word
//   data_out     : last accepted word (bit 0 = first bit received)
//   data_valid   : data_out holds an unconsumed word
//   data_ready   : downstream takes data_out when data_valid && data_ready
//   overrun      : sticky, a completed word was dropped (register full)
//   frame_err    : one-cycle pulse, frame_start hit a partially received word
//   clr_overrun  : clears overrun (a simultaneous new overrun wins)
module deserializer_rx
    import serdes_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W,
    parameter int unsigned CNT_W = serdes_pkg::CNT_W
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
    output logic             frame_err,
    input  logic             clr_overrun
);

    localparam bit ONE_BIT = (WIDTH == 1);

    state_t             state;
    logic [WIDTH-1:0]   shift_reg;
    logic [WIDTH-1:0]   word;
    logic [CNT_W-1:0]   cnt;
    logic               last_bit;
    logic               start;
    logic               advance;
    logic               complete;
    logic               consume;

    // A framed bit restarts the word in either state; in SHIFT it also
    // aborts the partial word.
    assign start    = bit_valid && frame_start;
    assign advance  = bit_valid && !frame_start && (state == ST_SHIFT);
    assign complete = (start && ONE_BIT) || (advance && last_bit);
    assign consume  = data_valid && data_ready;

    // The final bit is taken straight from serial_in so the word can be
    // loaded on the same edge it is sampled.
    always_comb begin
        word            = shift_reg;
        word[WIDTH-1]   = serial_in;
    end

    deser_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .CLK      (CLK),
        .rst      (rst),
        .start    (start),
        .advance  (advance),
        .cnt      (cnt),
        .last_bit (last_bit)
    );

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= start && (state == ST_SHIFT);

            // Shift register and state
            if (start) begin
                shift_reg    <= '0;
                shift_reg[0] <= serial_in;
                state        <= ONE_BIT ? ST_IDLE : ST_SHIFT;
            end else if (advance) begin
                shift_reg[cnt] <= serial_in;
                if (last_bit) begin
                    state <= ST_IDLE;
                end
            end

            // Output register: a word completing while the old one is being
            // consumed replaces it with no bubble.
            if (clr_overrun) begin
                overrun <= 1'b0;
            end
            if (complete) begin
                if (!data_valid || data_ready) begin
                    data_out   <= word;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (consume) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_deserializer_rx.sv
module tb_deserializer_rx;

    logic        CLK;
    logic        rst;
    logic        serial_in;
    logic        bit_valid;
    logic        frame_start;
    logic [11:0] data_out;
    logic        data_valid;
    logic        data_ready;
    logic        overrun;
    logic        frame_err;
    logic        clr_overrun;

    int errors = 0;
    int checks = 0;

    deserializer_rx #(
        .WIDTH (12),
        .CNT_W (4)
    ) dut (
        .CLK         (CLK),
        .rst         (rst),
        .serial_in   (serial_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .clr_overrun (clr_overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance to the next falling edge and drive an idle bus.
    task automatic next_idle();
        @(negedge CLK);
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        serial_in   = 1'b0;
    endtask

    // Send a framed word LSB-first, with 'gap' idle cycles between bits.
    // exp_valid >= 0 checks data_valid at every falling edge before driving.
    task automatic send_word(input logic [11:0] w, input int gap, input int exp_valid);
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (exp_valid >= 0) begin
                checks++;
                if (data_valid !== exp_valid[0]) begin
                    errors++;
                    $display("FAIL word_valid bit %0d: got %b want %0d", i, data_valid, exp_valid);
                end
            end
            bit_valid   = 1'b1;
            serial_in   = w[i];
            frame_start = (i == 0);
            if (i < 11) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge CLK);
                    if (exp_valid >= 0) begin
                        checks++;
                        if (data_valid !== exp_valid[0]) begin
                            errors++;
                            $display("FAIL gap_valid bit %0d gap %0d: got %b want %0d", i, g, data_valid, exp_valid);
                        end
                    end
                    bit_valid   = 1'b0;
                    frame_start = 1'b0;
                    serial_in   = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        serial_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
        data_ready = 1'b0; clr_overrun = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if ({data_out, data_valid, overrun, frame_err} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got out=%h v=%b ovr=%b ferr=%b want all 0", data_out, data_valid, overrun, frame_err);
        end
        rst = 1'b0;
        next_idle();
        checks++;
        if ({data_valid, overrun, frame_err} !== 3'd0) begin
            errors++;
            $display("FAIL post_reset_flags: got v=%b ovr=%b ferr=%b want 0", data_valid, overrun, frame_err);
        end
    endtask

    task automatic test_basic_word();
        data_ready = 1'b1;
        send_word(12'hA5C, 0, 0);
        next_idle();
        checks++;
        if (data_valid !== 1'b1 || data_out !== 12'hA5C) begin
            errors++;
            $display("FAIL basic_word: got v=%b out=%h want v=1 out=a5c", data_valid, data_out);
        end
        checks++;
        if (overrun !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_flags: got ovr=%b ferr=%b want 0 0", overrun, frame_err);
        end
        next_idle();
        checks++;
        if (data_valid !== 1'b0 || data_out !== 12'hA5C) begin
            errors++;
            $display("FAIL basic_consumed: got v=%b out=%h want v=0 out=a5c", data_valid, data_out);
        end
    endtask

    task automatic test_gapped();
        data_ready = 1'b1;
        send_word(12'hA5C, 3, 0);
        next_idle();
        checks++;
        if (data_valid !== 1'b1 || data_out !== 12'hA5C) begin
            errors++;
            $display("FAIL gapped_word: got v=%b out=%h want v=1 out=a5c", data_valid, data_out);
        end
        next_idle();
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL gapped_consumed: got v=%b want 0", data_valid);
        end
    endtask

    task automatic test_overrun();
        data_ready = 1'b0;
        send_word(12'h123, 0, 0);
        next_idle();
        checks++;
        if (data_valid !== 1'b1 || data_out !== 12'h123 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL bp_first: got v=%b out=%h ovr=%b want 1 123 0", data_valid, data_out, overrun);
        end
        send_word(12'hFFF, 0, 1);
        next_idle();
        checks++;
        if (data_valid !== 1'b1 || data_out !== 12'h123 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL bp_overrun: got v=%b out=%h ovr=%b want 1 123 1", data_valid, data_out, overrun);
        end
        clr_overrun = 1'b1;
        next_idle();
        clr_overrun = 1'b0;
        checks++;
        if (overrun !== 1'b0 || data_valid !== 1'b1 || data_out !== 12'h123) begin
            errors++;
            $display("FAIL bp_clear: got ovr=%b v=%b out=%h want 0 1 123", overrun, data_valid, data_out);
        end
        data_ready = 1'b1;
        next_idle();
        checks++;
        if (data_valid !== 1'b0 || data_out !== 12'h123) begin
            errors++;
            $display("FAIL bp_drain: got v=%b out=%h want 0 123", data_valid, data_out);
        end
    endtask

    task automatic test_back_to_back();
        data_ready = 1'b0;
        send_word(12'h800, 0, 0);
        next_idle();
        checks++;
        if (data_valid !== 1'b1 || data_out !== 12'h800) begin
            errors++;
            $display("FAIL b2b_first: got v=%b out=%h want 1 800", data_valid, data_out);
        end
        send_word(12'h001, 0, 1);
        // consume word 1 on the very edge word 2 completes
        data_ready = 1'b1;
        next_idle();
        data_ready = 1'b0;
        checks++;
        if (data_valid !== 1'b1 || data_out !== 12'h001 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got v=%b out=%h ovr=%b want 1 001 0", data_valid, data_out, overrun);
        end
        data_ready = 1'b1;
        next_idle();
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got v=%b want 0", data_valid);
        end
    endtask

    task automatic test_resync();
        logic [11:0] w;
        w = 12'h3C3;
        data_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            bit_valid = 1'b1; serial_in = 1'b1; frame_start = (i == 0);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            checks++;
            if (frame_err !== (i == 1)) begin
                errors++;
                $display("FAIL resync_ferr bit %0d: got %b want %0d", i, frame_err, (i == 1));
            end
            checks++;
            if (data_valid !== 1'b0) begin
                errors++;
                $display("FAIL resync_no_partial bit %0d: got v=%b want 0", i, data_valid);
            end
            bit_valid = 1'b1; serial_in = w[i]; frame_start = (i == 0);
        end
        next_idle();
        checks++;
        if (data_valid !== 1'b1 || data_out !== 12'h3C3 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL resync_word: got v=%b out=%h ferr=%b want 1 3c3 0", data_valid, data_out, frame_err);
        end
        next_idle();
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL resync_drain: got v=%b want 0", data_valid);
        end
    endtask

    task automatic test_reset_mid_word();
        data_ready = 1'b0;
        send_word(12'h0F0, 0, 0);
        send_word(12'hFFF, 0, 1);
        next_idle();
        checks++;
        if (overrun !== 1'b1 || data_valid !== 1'b1 || data_out !== 12'h0F0) begin
            errors++;
            $display("FAIL rst_setup: got ovr=%b v=%b out=%h want 1 1 0f0", overrun, data_valid, data_out);
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            bit_valid = 1'b1; serial_in = 1'b1; frame_start = (i == 0);
        end
        @(posedge CLK);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({data_out, data_valid, overrun, frame_err} !== 15'd0) begin
            errors++;
            $display("FAIL rst_async: got out=%h v=%b ovr=%b ferr=%b want all 0", data_out, data_valid, overrun, frame_err);
        end
        next_idle();
        rst = 1'b0;
        data_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            checks++;
            if (data_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_unframed bit %0d: got v=%b want 0", i, data_valid);
            end
            bit_valid = 1'b1; serial_in = 1'b1; frame_start = 1'b0;
        end
        send_word(12'h5A5, 0, 0);
        next_idle();
        checks++;
        if (data_valid !== 1'b1 || data_out !== 12'h5A5 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL rst_fresh_word: got v=%b out=%h ovr=%b want 1 5a5 0", data_valid, data_out, overrun);
        end
    endtask

    initial begin
        test_reset();
        test_basic_word();
        test_gapped();
        test_overrun();
        test_back_to_back();
        test_resync();
        test_reset_mid_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
